// File: rtl/face_detect_mul_pkg.sv
// Shared helpers for face_detect_mul_pipe: product width, saturation bounds and
// parameter legality.
package face_detect_mul_pkg;

  localparam int MAXW = 128;

  typedef logic signed [MAXW-1:0] wide_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic wide_t wide_one();
    return {{(MAXW-1){1'b0}}, 1'b1};
  endfunction

  function automatic wide_t sat_smax(input int w);
    return (wide_one() <<< (w - 1)) - wide_one();
  endfunction

  function automatic wide_t sat_smin(input int w);
    return -(wide_one() <<< (w - 1));
  endfunction

  function automatic wide_t sat_umax(input int w);
    return (wide_one() <<< w) - wide_one();
  endfunction

  function automatic wide_t sat_umin();
    return '0;
  endfunction

  // Bounds kept below MAXW so the saturation compare never overflows wide_t.
  function automatic bit params_legal(input int w0, input int w1, input int wo,
                                      input int ns, input int sh);
    return (w0 >= 2) && (w1 >= 2) && (wo >= 2) && (wo <= w0 + w1) &&
           (ns >= 1) && (sh >= 0) && (sh <= w0 + w1 - 1) &&
           (prod_width(w0, w1) < MAXW);
  endfunction

endpackage

// File: rtl/face_detect_pipe_stage.sv
// One delay stage of the multiplier pipeline: valid, data and (with
// FACE_DETECT_MUL_SAT_EN) ovf, advancing together under a shared enable.
module face_detect_pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef FACE_DETECT_MUL_SAT_EN
  input  logic              ovf_i,
  output logic              ovf_o,
`endif
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  // Data only moves on a real beat so the output holds its last result across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (adv_i) begin
      vld_q <= vld_i;
      if (vld_i) data_q <= data_i;
    end
  end

`ifdef FACE_DETECT_MUL_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (adv_i && vld_i) begin
      ovf_q <= ovf_i;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/face_detect_mul_pipe.sv
// Handshaked multiplier with per-operand signedness, post-multiply arithmetic shift
// and a NUM_STAGE-deep stalling pipeline. Define FACE_DETECT_MUL_SAT_EN to saturate.
module face_detect_mul_pipe
  import face_detect_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 32,
  parameter int DOUT_WIDTH  = 32,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 2,
  parameter int SHIFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  if (!params_legal(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, NUM_STAGE, SHIFT)) begin : g_bad_params
    $error("face_detect_mul_pipe: illegal parameter combination");
  end

  logic stall;
  logic advance;

  // A single global stall freezes every stage; in_ready is masked during reset.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ce & ~stall;
  assign in_ready = advance & ~reset;

  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       s_p0;
  logic [DOUT_WIDTH-1:0]      data_d;

  assign a_ext = {((DIN0_SIGNED != 0) && din0[DIN0_WIDTH-1]), din0};
  assign b_ext = {((DIN1_SIGNED != 0) && din1[DIN1_WIDTH-1]), din1};
  assign prod  = PW'(a_ext) * PW'(b_ext);
  assign s_p0  = prod >>> SHIFT;

`ifdef FACE_DETECT_MUL_SAT_EN
  localparam bit    BOTH_UNSIGNED = (DIN0_SIGNED == 0) && (DIN1_SIGNED == 0);
  localparam wide_t SAT_HI = BOTH_UNSIGNED ? sat_umax(DOUT_WIDTH) : sat_smax(DOUT_WIDTH);
  localparam wide_t SAT_LO = BOTH_UNSIGNED ? sat_umin()           : sat_smin(DOUT_WIDTH);

  wide_t s_wide;
  logic  ovf_d;

  assign s_wide = wide_t'(s_p0);

  always_comb begin
    data_d = s_p0[DOUT_WIDTH-1:0];
    ovf_d  = 1'b0;
    if (s_wide > SAT_HI) begin
      data_d = SAT_HI[DOUT_WIDTH-1:0];
      ovf_d  = 1'b1;
    end else if (s_wide < SAT_LO) begin
      data_d = SAT_LO[DOUT_WIDTH-1:0];
      ovf_d  = 1'b1;
    end
  end
`else
  logic unused_s_hi;

  assign data_d      = s_p0[DOUT_WIDTH-1:0];
  assign unused_s_hi = ^s_p0[PW-1:DOUT_WIDTH];
`endif

  // ---- stage 1: register the scaled result with its valid ----
  logic                  vld_p1_q;
  logic [DOUT_WIDTH-1:0] data_p1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else if (advance) begin
      vld_p1_q <= in_valid;
      if (in_valid) data_p1_q <= data_d;
    end
  end

`ifdef FACE_DETECT_MUL_SAT_EN
  logic ovf_p1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_p1_q <= 1'b0;
    end else if (advance && in_valid) begin
      ovf_p1_q <= ovf_d;
    end
  end
`endif

  // ---- stages 2..NUM_STAGE: pure delay ----
  logic                  vld_s  [NUM_STAGE];
  logic [DOUT_WIDTH-1:0] data_s [NUM_STAGE];

  assign vld_s[0]  = vld_p1_q;
  assign data_s[0] = data_p1_q;

`ifdef FACE_DETECT_MUL_SAT_EN
  logic ovf_s [NUM_STAGE];

  assign ovf_s[0] = ovf_p1_q;
`endif

  for (genvar g = 1; g < NUM_STAGE; g++) begin : g_stage
    face_detect_pipe_stage #(
      .DATA_W (DOUT_WIDTH)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .adv_i  (advance),
      .vld_i  (vld_s[g-1]),
      .data_i (data_s[g-1]),
`ifdef FACE_DETECT_MUL_SAT_EN
      .ovf_i  (ovf_s[g-1]),
      .ovf_o  (ovf_s[g]),
`endif
      .vld_o  (vld_s[g]),
      .data_o (data_s[g])
    );
  end

  assign out_valid = vld_s[NUM_STAGE-1];
  assign dout      = data_s[NUM_STAGE-1];

`ifdef FACE_DETECT_MUL_SAT_EN
  assign ovf = ovf_s[NUM_STAGE-1];
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_face_detect_mul_pipe.sv
// Directed bench for face_detect_mul_pipe: four configurations share one stimulus
// stream; expectations are hand-computed constants.
module tb_face_detect_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [31:0] din1;

  logic        rdy_a, vld_a, ovf_a;
  logic [31:0] dout_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [31:0] dout_b;
  logic        rdy_c, vld_c, ovf_c;
  logic [15:0] dout_c;
  logic        rdy_d, vld_d, ovf_d;
  logic [31:0] dout_d;

  int vectors    = 0;
  int miscompares = 0;
  int sent;
  int recv;
  logic [31:0] held;

  always #5 clk = ~clk;

  face_detect_mul_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_a),
    .din0(din0), .din1(din1), .out_valid(vld_a), .out_ready(out_ready),
    .dout(dout_a), .ovf(ovf_a)
  );

  face_detect_mul_pipe #(.DIN0_SIGNED(1)) u_s0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_b),
    .din0(din0), .din1(din1), .out_valid(vld_b), .out_ready(out_ready),
    .dout(dout_b), .ovf(ovf_b)
  );

  face_detect_mul_pipe #(.DOUT_WIDTH(16)) u_w16 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_c),
    .din0(din0), .din1(din1), .out_valid(vld_c), .out_ready(out_ready),
    .dout(dout_c), .ovf(ovf_c)
  );

  face_detect_mul_pipe #(.SHIFT(4)) u_sh (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy_d),
    .din0(din0), .din1(din1), .out_valid(vld_d), .out_ready(out_ready),
    .dout(dout_d), .ovf(ovf_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-beat transfer; returns on the cycle its result should be at the output.
  task automatic send(input logic [13:0] a, input logic [31:0] b);
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    cyc();
    cyc();
    chk("rst_in_ready",  64'(rdy_a),  64'd0);
    chk("rst_out_valid", 64'(vld_a),  64'd0);
    chk("rst_dout",      64'(dout_a), 64'd0);
    chk("rst_ovf",       64'(ovf_a),  64'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_idle", 64'(rdy_a), 64'd1);
    cyc();

    // 3 * -5, latency of exactly two cycles
    din0     = 14'd3;
    din1     = 32'hFFFF_FFFB;
    in_valid = 1'b1;
    #1;
    chk("accept_in_ready", 64'(rdy_a), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("lat1_out_valid", 64'(vld_a), 64'd0);
    cyc();
    chk("lat2_out_valid", 64'(vld_a),  64'd1);
    chk("mul_3_m5",       64'(dout_a), 64'hFFFF_FFF1);
    chk("mul_3_m5_ovf",   64'(ovf_a),  64'd0);
    cyc();
    chk("drained_out_valid", 64'(vld_a),  64'd0);
    chk("dout_holds",        64'(dout_a), 64'hFFFF_FFF1);

    // 14'h3FFF as unsigned and as signed
    send(14'h3FFF, 32'd7);
    chk("u0_3fff_x7",  64'(dout_a), 64'h0001_BFF9);
    chk("s0_vld",      64'(vld_b),  64'd1);
    chk("s0_3fff_x7",  64'(dout_b), 64'hFFFF_FFF9);
    cyc();

    // 16-bit result: wrap or saturate
    send(14'd16383, 32'd32767);
    chk("w16_vld", 64'(vld_c), 64'd1);
`ifdef FACE_DETECT_MUL_SAT_EN
    chk("w16_dout", 64'(dout_c), 64'h7FFF);
    chk("w16_ovf",  64'(ovf_c),  64'd1);
`else
    chk("w16_dout", 64'(dout_c), 64'h4001);
    chk("w16_ovf",  64'(ovf_c),  64'd0);
`endif
    cyc();

    // SHIFT=4 floors toward minus infinity
    send(14'd100, 32'hFFFF_FFFD);
    chk("sh4_dout",   64'(dout_d), 64'hFFFF_FFED);
    chk("sh0_m300",   64'(dout_a), 64'hFFFF_FED4);
    cyc();

    // ce low freezes the pipeline
    din0     = 14'd5;
    din1     = 32'd6;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    ce       = 1'b0;
    #1;
    chk("ce_in_ready", 64'(rdy_a), 64'd0);
    cyc();
    cyc();
    chk("ce_frozen_out_valid", 64'(vld_a), 64'd0);
    ce = 1'b1;
    cyc();
    chk("ce_resume_out_valid", 64'(vld_a),  64'd1);
    chk("ce_resume_dout",      64'(dout_a), 64'd30);
    cyc();

    // 8 back-to-back operands with out_ready low on cycles 4..6
    sent = 0;
    recv = 0;
    held = '0;
    for (int c = 0; c < 30 && recv < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (sent < 8);
      din0      = 14'(sent + 1);
      din1      = 32'd1000;
      #1;
      if (c >= 4 && c <= 6) begin
        chk("stall_in_ready", 64'(rdy_a), 64'd0);
        if (c == 4) held = dout_a;
        else        chk("stall_dout_hold", 64'(dout_a), 64'(held));
      end
      if (vld_a && out_ready) begin
        chk("stream_dout", 64'(dout_a), 64'((recv + 1) * 1000));
        recv++;
      end
      if (in_valid && rdy_a) sent++;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_recv", 64'(recv), 64'd8);
    cyc();

    // reset with two results in flight
    out_ready = 1'b0;
    din0      = 14'd7;
    din1      = 32'd8;
    in_valid  = 1'b1;
    cyc();
    din0 = 14'd9;
    din1 = 32'd10;
    cyc();
    in_valid = 1'b0;
    chk("inflight_out_valid", 64'(vld_a),  64'd1);
    chk("inflight_dout",      64'(dout_a), 64'd56);
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(vld_a),  64'd0);
    chk("async_rst_in_ready",  64'(rdy_a),  64'd0);
    chk("async_rst_dout",      64'(dout_a), 64'd0);
    cyc();
    reset     = 1'b0;
    out_ready = 1'b1;
    din0      = 14'd11;
    din1      = 32'd12;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_no_stale", 64'(vld_a), 64'd0);
    cyc();
    chk("post_rst_out_valid", 64'(vld_a),  64'd1);
    chk("post_rst_dout",      64'(dout_a), 64'd132);
    cyc();
    chk("post_rst_drained", 64'(vld_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/face_detect_mul_pipe.md
# face_detect_mul_pipe

Parametrised, handshaked integer multiplier for the face-detect datapath. It is the next generation of the fixed-latency `mul_*_2_1` cores. It adds:
- configurable operand and result widths;
- per-operand signedness;
- configurable pipeline depth;
- a post-multiply arithmetic right shift;
- valid/ready flow control with back-pressure.

It sits between feature-accumulation stages that need scaled products and cannot guarantee a consumer is always ready.

## Interface
Parameters:
- DIN0_WIDTH, 14, operand 0 width (≥2)
- DIN1_WIDTH, 32, operand 1 width (≥2)
- DOUT_WIDTH, 32, result width (≥2, ≤ DIN0_WIDTH+DIN1_WIDTH)
- DIN0_SIGNED, 0, 1 = din0 is two's complement; 0 = zero-extended
- DIN1_SIGNED, 1, same for din1
- NUM_STAGE, 2, register stages from accept to output (≥1)
- SHIFT, 0, arithmetic right shift applied to the full product (0..DIN0_WIDTH+DIN1_WIDTH−1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- ce  in  1  global clock enable; low freezes all registers
- in_valid  in  1  operands presented
- in_ready  out  1  block accepts operands this cycle
- din0  in  DIN0_WIDTH  operand 0
- din1  in  DIN1_WIDTH  operand 1
- out_valid  out  1  dout holds a result
- out_ready  in  1  consumer takes dout this cycle
- dout  out  DOUT_WIDTH  result
- ovf  out  1  result did not fit DOUT_WIDTH (saturation builds only)

## Operation
- Each operand is extended by one bit: sign-extended if its *_SIGNED is 1, else zero-extended.
- Full product P = ext(din0) × ext(din1), signed, width PW = DIN0_WIDTH+DIN1_WIDTH+2. No loss at this step.
- Scaled value S = P >>> SHIFT (arithmetic shift, floor rounding).
- Result:
  - Default: dout = S[DOUT_WIDTH−1:0] (wrap).
  - With saturation: see Configuration.
- Pipeline: stage 1 registers S together with a valid bit. Stages 2..NUM_STAGE are pure delay registers for data, valid and ovf. The last stage drives dout, out_valid and ovf.
- Flow control is a global stall:
  - stall = out_valid & ~out_ready
  - advance = ce & ~stall
  - in_ready = advance (combinational)
- A transfer in occurs when in_valid & in_ready. A transfer out occurs when out_valid & out_ready.
- When advance = 1, every stage shifts by one and stage 1 takes valid = in_valid.
- When advance = 0, all stages, dout and out_valid hold. Accepted data is never dropped or duplicated.
- Bubbles travel through the pipeline; they are not collapsed.

## Timing
- Reset values: in_ready = 0 while reset is asserted; out_valid = 0, dout = 0, ovf = 0. All stage valid bits and data are 0.
- Latency: an accept at cycle N gives out_valid = 1 at cycle N+NUM_STAGE, provided no stall and ce stays high.
- Throughput: 1 result per cycle when out_ready is held high.
- Simultaneous out transfer and in accept in the same cycle is legal and required to work at full rate.
- ce = 0 has priority over everything except reset. in_ready = 0 for those cycles and outputs hold.
- Reset asserted mid-operation: all in-flight results are discarded asynchronously. out_valid falls immediately, not at the next edge.
- When out_valid = 0, dout holds its last value; a consumer must ignore dout unless out_valid = 1.

## Configuration
- FACE_DETECT_MUL_SAT_EN defined:
  - If S exceeds the signed DOUT_WIDTH range, dout clamps to max positive or min negative.
  - If both operands are unsigned, the range is the unsigned DOUT_WIDTH range.
  - ovf = 1 in that result's beat; ovf is pipelined alongside the data.
- Not defined: wrap truncation; ovf is tied to 0 and has no register.

## Structure
- Shared package face_detect_mul_pkg:
  - function computing PW;
  - saturation-bound functions (signed/unsigned max/min for a given width);
  - parameter legality checks (elaboration-time assertions).
- One sub-module, face_detect_pipe_stage: a single data+valid+ovf register with advance enable and async reset. It is instantiated NUM_STAGE−1 times in a generate loop after the arithmetic stage.

## Test plan
- Defaults, din0 = 3, din1 = −5, in_valid for 1 cycle -> out_valid exactly 2 cycles later, dout = 32'hFFFF_FFF1, ovf = 0.
- DIN0_SIGNED = 1, DIN0_WIDTH = 14, din0 = 14'h3FFF (−1), din1 = 7 -> dout = −7. Same with DIN0_SIGNED = 0 -> dout = 114681.
- DOUT_WIDTH = 16, din0 = 16383, din1 = 32767:
  - with FACE_DETECT_MUL_SAT_EN -> dout = 16'h7FFF, ovf = 1;
  - without the macro -> dout = 16'h4001, ovf = 0.
- SHIFT = 4, din0 = 100, din1 = −3 -> dout = −19 (floor of −18.75).
- Stream 8 back-to-back operands, hold out_ready = 0 for cycles 4–6:
  - in_ready = 0 during the stall;
  - dout stable during the stall;
  - all 8 results appear in order with none lost.
- Assert reset while 2 results are in flight -> out_valid = 0 immediately. After release, a fresh operand pair emerges after NUM_STAGE cycles with no stale data.
